// File: rtl/mem_read_arbiter.sv
// Two-requester (icache/dcache) line-read arbiter onto a single-outstanding
// burst read bus. Each accepted request becomes one 4-beat INCR burst whose
// beats are assembled into a 128-bit line and returned to the requester.
module mem_read_arbiter #(
  parameter bit DCACHE_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,

  input  logic         i_ren,
  input  logic [31:0]  i_raddr,
  output logic         i_rrdy,
  output logic         i_ren_received,
  output logic         i_rvalid,
  output logic [127:0] i_rdata,
  output logic         i_flush_flag_valid,

  input  logic         d_ren,
  input  logic [31:0]  d_raddr,
  output logic         d_rrdy,
  output logic         d_ren_received,
  output logic         d_rvalid,
  output logic [127:0] d_rdata,

  output logic         ar_valid,
  input  logic         ar_ready,
  output logic [31:0]  ar_addr,
  output logic [3:0]   ar_id,
  output logic [7:0]   ar_len,
  output logic [2:0]   ar_size,
  output logic [1:0]   ar_burst,

  input  logic         r_valid,
  output logic         r_ready,
  input  logic [31:0]  r_data,
  input  logic         r_last
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned LW = 128;
  localparam int unsigned CW = 2;
  localparam logic [AW-1:0] LINE_MASK = 32'hFFFF_FFF0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR_I = 3'd1,
    S_AR_D = 3'd2,
    S_R_I  = 3'd3,
    S_R_D  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q;
  logic [AW-1:0]   launch_addr;
  logic            launch;
  logic [CW-1:0]   cnt_q;
  logic [LW-1:0]   line_q, line_d;
  logic            beat;
  logic            fin;
  logic            ar_hs;

  // Burst shape is fixed: 4 beats of 32 bits, incrementing.
  assign ar_len   = 8'd3;
  assign ar_size  = 3'b010;
  assign ar_burst = 2'b01;
  assign ar_addr  = addr_q;

  // Next-state decode, arbitration and state-derived handshake outputs.
  always_comb begin
    state_d        = state_q;
    i_rrdy         = 1'b0;
    d_rrdy         = 1'b0;
    ar_valid       = 1'b0;
    ar_id          = 4'd0;
    r_ready        = 1'b0;
    i_ren_received = 1'b0;
    d_ren_received = 1'b0;
    launch         = 1'b0;
    launch_addr    = i_raddr;
    unique case (state_q)
      S_IDLE: begin
        i_rrdy = 1'b1;
        d_rrdy = 1'b1;
        if (d_ren && (!i_ren || DCACHE_FIRST)) begin
          state_d     = S_AR_D;
          launch      = 1'b1;
          launch_addr = d_raddr;
        end else if (i_ren) begin
          state_d = S_AR_I;
          launch  = 1'b1;
        end
      end
      S_AR_I: begin
        ar_valid = 1'b1;
        if (ar_ready) begin
          i_ren_received = 1'b1;
          state_d        = S_R_I;
        end
      end
      S_AR_D: begin
        ar_valid = 1'b1;
        ar_id    = 4'd1;
        if (ar_ready) begin
          d_ren_received = 1'b1;
          state_d        = S_R_D;
        end
      end
      S_R_I, S_R_D: begin
        r_ready = 1'b1;
        if (r_valid && r_last) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line buffer with the current beat merged into its slot.
  always_comb begin
    beat   = r_valid && r_ready;
    fin    = beat && r_last;
    ar_hs  = ar_valid && ar_ready;
    line_d = line_q;
    if (beat) line_d[{cnt_q, 5'd0} +: DW] = r_data;
  end

  // State, latched line address, beat counter and assembly buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      state_q <= state_d;
      if (launch) addr_q <= launch_addr & LINE_MASK;
      if (ar_hs) cnt_q <= '0;
      else if (beat) cnt_q <= cnt_q + CW'(1);
      if (beat) line_q <= line_d;
    end
  end

  // Per-requester completion pulse, held line data and icache outstanding flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      i_rvalid           <= 1'b0;
      d_rvalid           <= 1'b0;
      i_rdata            <= '0;
      d_rdata            <= '0;
      i_flush_flag_valid <= 1'b0;
    end else begin
      i_rvalid <= fin && (state_q == S_R_I);
      d_rvalid <= fin && (state_q == S_R_D);
      if (fin && (state_q == S_R_I)) i_rdata <= line_d;
      if (fin && (state_q == S_R_D)) d_rdata <= line_d;
      if (ar_hs && (state_q == S_AR_I)) i_flush_flag_valid <= 1'b1;
      else if (i_rvalid) i_flush_flag_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Scoreboard bench for mem_read_arbiter: directed transactions push expected
// AR requests and returned lines; a negedge monitor pops and compares.
module tb_mem_read_arbiter;

  logic         clk = 1'b0;
  logic         rst;
  logic         i_ren, d_ren;
  logic [31:0]  i_raddr, d_raddr;
  logic         i_rrdy, i_ren_received, i_rvalid, i_flush_flag_valid;
  logic         d_rrdy, d_ren_received, d_rvalid;
  logic [127:0] i_rdata, d_rdata;
  logic         ar_valid, ar_ready;
  logic [31:0]  ar_addr;
  logic [3:0]   ar_id;
  logic [7:0]   ar_len;
  logic [2:0]   ar_size;
  logic [1:0]   ar_burst;
  logic         r_valid, r_ready, r_last;
  logic [31:0]  r_data;

  // second instance with icache priority, sharing all inputs
  logic         u2_i_rrdy, u2_i_ren_received, u2_i_rvalid, u2_i_flush;
  logic         u2_d_rrdy, u2_d_ren_received, u2_d_rvalid;
  logic [127:0] u2_i_rdata, u2_d_rdata;
  logic         u2_ar_valid, u2_r_ready;
  logic [31:0]  u2_ar_addr;
  logic [3:0]   u2_ar_id;
  logic [7:0]   u2_ar_len;
  logic [2:0]   u2_ar_size;
  logic [1:0]   u2_ar_burst;

  always #5 clk = ~clk;

  mem_read_arbiter #(.DCACHE_FIRST(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_raddr(i_raddr), .i_rrdy(i_rrdy), .i_ren_received(i_ren_received),
    .i_rvalid(i_rvalid), .i_rdata(i_rdata), .i_flush_flag_valid(i_flush_flag_valid),
    .d_ren(d_ren), .d_raddr(d_raddr), .d_rrdy(d_rrdy), .d_ren_received(d_ren_received),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_id(ar_id),
    .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last)
  );

  mem_read_arbiter #(.DCACHE_FIRST(1'b0)) u_dut_ifirst (
    .clk(clk), .rst(rst),
    .i_ren(i_ren), .i_raddr(i_raddr), .i_rrdy(u2_i_rrdy), .i_ren_received(u2_i_ren_received),
    .i_rvalid(u2_i_rvalid), .i_rdata(u2_i_rdata), .i_flush_flag_valid(u2_i_flush),
    .d_ren(d_ren), .d_raddr(d_raddr), .d_rrdy(u2_d_rrdy), .d_ren_received(u2_d_ren_received),
    .d_rvalid(u2_d_rvalid), .d_rdata(u2_d_rdata),
    .ar_valid(u2_ar_valid), .ar_ready(ar_ready), .ar_addr(u2_ar_addr), .ar_id(u2_ar_id),
    .ar_len(u2_ar_len), .ar_size(u2_ar_size), .ar_burst(u2_ar_burst),
    .r_valid(r_valid), .r_ready(u2_r_ready), .r_data(r_data), .r_last(r_last)
  );

  typedef struct {
    int           stall;
    bit           junk;
    int           nbeats;
    bit           send_last;
    logic [15:0]  vpat;
    logic [127:0] beats;
  } bus_cfg_t;

  bus_cfg_t     cfg_q[$];
  logic [35:0]  exp_ar[$];
  logic [127:0] exp_i[$];
  logic [127:0] exp_d[$];
  int           checks = 0;
  int           errors = 0;
  bit           resp_busy = 1'b0;

  task automatic chk(input bit ok, input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add_txn(input bit is_d, input logic [31:0] line_addr, input int stall, input bit junk,
                         input int nbeats, input bit send_last, input logic [15:0] vpat,
                         input logic [127:0] beats, input logic [127:0] exp_line, input bit completes);
    bus_cfg_t c;
    c.stall = stall; c.junk = junk; c.nbeats = nbeats; c.send_last = send_last;
    c.vpat = vpat; c.beats = beats;
    cfg_q.push_back(c);
    exp_ar.push_back({(is_d ? 4'd1 : 4'd0), line_addr});
    if (completes) begin
      if (is_d) exp_d.push_back(exp_line);
      else exp_i.push_back(exp_line);
    end
  endtask

  // Bus slave: per queued config, accept AR after a stall, then return beats.
  initial begin
    bus_cfg_t c;
    int n, idx, k;
    ar_ready = 1'b0; r_valid = 1'b0; r_data = '0; r_last = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (cfg_q.size() != 0) begin
        c = cfg_q.pop_front();
        resp_busy = 1'b1;
        n = 0;
        while (!ar_valid && n < 300) begin @(posedge clk); #1; n++; end
        if (!ar_valid) chk(1'b0, "ar_valid_timeout", 128'(n), 128'(300));
        else begin
          for (int s = 0; s < c.stall; s++) begin
            r_valid = c.junk; r_data = 32'hDEAD_BEEF; r_last = c.junk;
            @(posedge clk); #1;
          end
          r_valid = 1'b0; r_last = 1'b0; ar_ready = 1'b1;
          @(posedge clk); #1;
          ar_ready = 1'b0;
          idx = 0; k = 0;
          while (idx < c.nbeats && k < 64) begin
            r_valid = (k < 16) ? c.vpat[k[3:0]] : 1'b1;
            r_data  = r_valid ? c.beats[idx*32 +: 32] : 32'h0BAD_0BAD;
            r_last  = r_valid && c.send_last && (idx == c.nbeats - 1);
            if (r_valid) idx++;
            @(posedge clk); #1;
            k++;
          end
          r_valid = 1'b0; r_last = 1'b0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Monitor: scoreboard pops on AR handshakes and rvalid pulses, plus hold/flag models.
  logic [31:0]  m_addr0;
  logic [35:0]  m_e;
  logic [127:0] m_l;
  logic [3:0]   m_id = 4'd0;
  bit           m_arv_prev = 1'b0, m_pend_i = 1'b0, m_pend_d = 1'b0, m_flush = 1'b0;
  bit           m_irv_prev = 1'b0, m_drv_prev = 1'b0;
  logic [127:0] m_iprev = '0, m_dprev = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        m_arv_prev = 1'b0; m_pend_i = 1'b0; m_pend_d = 1'b0; m_flush = 1'b0;
        m_irv_prev = 1'b0; m_drv_prev = 1'b0;
      end else begin
        if (m_pend_i) chk(i_rvalid, "i_rvalid_after_last", 128'(i_rvalid), 128'(1));
        if (m_pend_d) chk(d_rvalid, "d_rvalid_after_last", 128'(d_rvalid), 128'(1));
        m_pend_i = 1'b0; m_pend_d = 1'b0;
        chk(i_flush_flag_valid == m_flush, "i_flush_flag_valid", 128'(i_flush_flag_valid), 128'(m_flush));
        if (ar_valid) begin
          if (m_arv_prev) chk(ar_addr == m_addr0, "ar_addr_stable", 128'(ar_addr), 128'(m_addr0));
          m_addr0 = ar_addr;
        end
        m_arv_prev = ar_valid && !ar_ready;
        if ((i_ren_received || d_ren_received) && !(ar_valid && ar_ready))
          chk(1'b0, "ren_received_no_handshake", 128'({i_ren_received, d_ren_received}), 128'(0));
        if (ar_valid && ar_ready) begin
          if (exp_ar.size() == 0) chk(1'b0, "unexpected_ar", 128'({ar_id, ar_addr}), 128'(0));
          else begin
            m_e = exp_ar.pop_front();
            chk({ar_id, ar_addr} == m_e, "ar_id_addr", 128'({ar_id, ar_addr}), 128'(m_e));
          end
          chk({ar_len, ar_size, ar_burst} == {8'd3, 3'b010, 2'b01}, "ar_len_size_burst",
              128'({ar_len, ar_size, ar_burst}), 128'({8'd3, 3'b010, 2'b01}));
          chk(i_ren_received == (ar_id == 4'd0) && d_ren_received == (ar_id == 4'd1), "ren_received",
              128'({i_ren_received, d_ren_received}), 128'({ar_id == 4'd0, ar_id == 4'd1}));
          m_id = ar_id;
        end
        if (i_rvalid) begin
          chk(!m_irv_prev, "i_rvalid_one_cycle", 128'(m_irv_prev), 128'(0));
          if (exp_i.size() == 0) chk(1'b0, "unexpected_i_rvalid", i_rdata, 128'(0));
          else begin
            m_l = exp_i.pop_front();
            chk(i_rdata == m_l, "i_rdata", i_rdata, m_l);
          end
        end else chk(i_rdata == m_iprev, "i_rdata_hold", i_rdata, m_iprev);
        if (d_rvalid) begin
          chk(!m_drv_prev, "d_rvalid_one_cycle", 128'(m_drv_prev), 128'(0));
          if (exp_d.size() == 0) chk(1'b0, "unexpected_d_rvalid", d_rdata, 128'(0));
          else begin
            m_l = exp_d.pop_front();
            chk(d_rdata == m_l, "d_rdata", d_rdata, m_l);
          end
        end else chk(d_rdata == m_dprev, "d_rdata_hold", d_rdata, m_dprev);
        if (r_valid && r_ready && r_last) begin
          m_pend_i = (m_id == 4'd0);
          m_pend_d = (m_id == 4'd1);
        end
        if (ar_valid && ar_ready && ar_id == 4'd0) m_flush = 1'b1;
        else if (i_rvalid) m_flush = 1'b0;
        m_irv_prev = i_rvalid; m_drv_prev = d_rvalid;
      end
      m_iprev = i_rdata; m_dprev = d_rdata;
    end
  end

  // Requester side: sample at negedge, drop requests once received.
  bit          s_ir, s_dr, s_irv, s_drv, s_last, s_arv, s_irrdy, s_u2arv;
  logic [3:0]  s_arid, s_u2arid;
  logic [31:0] s_araddr, s_u2araddr;

  task automatic step();
    @(negedge clk);
    s_ir = i_ren_received; s_dr = d_ren_received; s_irv = i_rvalid; s_drv = d_rvalid;
    s_last = r_valid && r_ready && r_last; s_arv = ar_valid; s_arid = ar_id; s_araddr = ar_addr;
    s_irrdy = i_rrdy; s_u2arv = u2_ar_valid; s_u2arid = u2_ar_id; s_u2araddr = u2_ar_addr;
    @(posedge clk); #1;
    if (s_ir) i_ren = 1'b0;
    if (s_dr) d_ren = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    step();
    while (!(cfg_q.size() == 0 && !resp_busy && exp_ar.size() == 0 && exp_i.size() == 0 &&
             exp_d.size() == 0 && i_rrdy && !i_ren && !d_ren) && n < 400) begin
      step(); n++;
    end
    chk(n < 400, name, 128'(n), 128'(400));
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({ar_valid, r_ready, i_ren_received, d_ren_received, i_rvalid, d_rvalid, i_flush_flag_valid} == 7'd0,
        {name, "_ctrl"}, 128'({ar_valid, r_ready, i_ren_received, d_ren_received, i_rvalid, d_rvalid,
        i_flush_flag_valid}), 128'(0));
    chk(ar_addr == 32'd0, {name, "_ar_addr"}, 128'(ar_addr), 128'(0));
    chk(i_rdata == 128'd0, {name, "_i_rdata"}, i_rdata, 128'(0));
    chk(d_rdata == 128'd0, {name, "_d_rdata"}, d_rdata, 128'(0));
    chk(i_rrdy && d_rrdy, {name, "_rrdy"}, 128'({i_rrdy, d_rrdy}), 128'(3));
  endtask

  initial begin
    int n;
    rst = 1'b0; i_ren = 1'b0; d_ren = 1'b0; i_raddr = '0; d_raddr = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b1;

    // single icache read
    i_raddr = 32'h1C00_0024; i_ren = 1'b1;
    add_txn(1'b0, 32'h1C00_0020, 0, 1'b0, 4, 1'b1, 16'hFFFF,
            {32'h44, 32'h33, 32'h22, 32'h11}, 128'h00000044_00000033_00000022_00000011, 1'b1);
    wait_idle("t1_single_icache_done");

    // simultaneous requests: dcache wins with DCACHE_FIRST=1, icache with 0
    i_raddr = 32'h0000_1238; d_raddr = 32'h8000_00FC;
    add_txn(1'b1, 32'h8000_00F0, 0, 1'b0, 4, 1'b1, 16'hFFFF,
            {32'hD000_0004, 32'hD000_0003, 32'hD000_0002, 32'hD000_0001},
            128'hD0000004_D0000003_D0000002_D0000001, 1'b1);
    add_txn(1'b0, 32'h0000_1230, 0, 1'b0, 4, 1'b1, 16'hFFFF,
            {32'h1000_0004, 32'h1000_0003, 32'h1000_0002, 32'h1000_0001},
            128'h10000004_10000003_10000002_10000001, 1'b1);
    i_ren = 1'b1; d_ren = 1'b1;
    step(); step();
    chk(s_arv && s_arid == 4'd1 && s_araddr == 32'h8000_00F0, "t2_dcache_first",
        128'({s_arv, s_arid, s_araddr}), 128'({1'b1, 4'd1, 32'h8000_00F0}));
    chk(s_u2arv && s_u2arid == 4'd0 && s_u2araddr == 32'h0000_1230, "t2_icache_first_param0",
        128'({s_u2arv, s_u2arid, s_u2araddr}), 128'({1'b1, 4'd0, 32'h0000_1230}));
    n = 0;
    while (!s_drv && n < 200) begin step(); n++; end
    chk(s_drv, "t2_d_rvalid_seen", 128'(s_drv), 128'(1));
    step();
    chk(s_arv && s_arid == 4'd0 && s_araddr == 32'h0000_1230, "t2_icache_ar_after_d_rvalid",
        128'({s_arv, s_arid, s_araddr}), 128'({1'b1, 4'd0, 32'h0000_1230}));
    wait_idle("t2_arbitration_done");

    // ar_ready stalled 5 cycles with stray r_valid, then gapped beats
    i_raddr = 32'h2000_004C; i_ren = 1'b1;
    add_txn(1'b0, 32'h2000_0040, 5, 1'b1, 4, 1'b1, 16'hFFD9,
            {32'hC0DE_0004, 32'hC0DE_0003, 32'hC0DE_0002, 32'hC0DE_0001},
            128'hC0DE0004_C0DE0003_C0DE0002_C0DE0001, 1'b1);
    wait_idle("t3_stall_gaps_done");

    // early r_last after 2 beats: upper slots keep previous buffer contents
    d_raddr = 32'h4000_0008; d_ren = 1'b1;
    add_txn(1'b1, 32'h4000_0000, 0, 1'b0, 2, 1'b1, 16'hFFFF,
            {64'd0, 32'h5555_0002, 32'h5555_0001},
            128'hC0DE0004_C0DE0003_55550002_55550001, 1'b1);
    wait_idle("t4_early_last_done");

    // back-to-back icache: new request sampled in the i_rvalid cycle
    i_raddr = 32'h0000_0100; i_ren = 1'b1;
    add_txn(1'b0, 32'h0000_0100, 0, 1'b0, 4, 1'b1, 16'hFFFF,
            {32'hE000_0004, 32'hE000_0003, 32'hE000_0002, 32'hE000_0001},
            128'hE0000004_E0000003_E0000002_E0000001, 1'b1);
    add_txn(1'b0, 32'h0000_0210, 0, 1'b0, 4, 1'b1, 16'hFFFF,
            {32'hF000_0004, 32'hF000_0003, 32'hF000_0002, 32'hF000_0001},
            128'hF0000004_F0000003_F0000002_F0000001, 1'b1);
    n = 0;
    step();
    while (!s_last && n < 200) begin step(); n++; end
    chk(s_last, "t5_first_last_seen", 128'(s_last), 128'(1));
    i_raddr = 32'h0000_0214; i_ren = 1'b1;
    step();
    chk(s_irv && s_irrdy, "t5_rvalid_in_idle", 128'({s_irv, s_irrdy}), 128'(3));
    step();
    chk(s_arv && s_arid == 4'd0 && s_araddr == 32'h0000_0210, "t5_back_to_back_ar",
        128'({s_arv, s_arid, s_araddr}), 128'({1'b1, 4'd0, 32'h0000_0210}));
    wait_idle("t5_back_to_back_done");

    // request pulsed and dropped between edges: nothing issued
    i_raddr = 32'h5000_0000; i_ren = 1'b1;
    #2;
    i_ren = 1'b0;
    for (int j = 0; j < 3; j++) begin
      step();
      chk(!s_arv, "t6_drop_no_ar", 128'(s_arv), 128'(0));
    end

    // reset after 2 beats of an icache read
    i_raddr = 32'h3000_0014; i_ren = 1'b1;
    add_txn(1'b0, 32'h3000_0010, 0, 1'b0, 2, 1'b0, 16'hFFFF,
            {64'd0, 32'h7777_0002, 32'h7777_0001}, 128'd0, 1'b0);
    n = 0;
    step();
    while (!(cfg_q.size() == 0 && !resp_busy) && n < 200) begin step(); n++; end
    chk(n < 200, "t7_two_beats_delivered", 128'(n), 128'(200));
    #2;
    rst = 1'b0;
    #1;
    chk_reset_outputs("t7_async_reset");
    for (int j = 0; j < 2; j++) begin
      step();
      chk(!s_irv, "t7_no_rvalid_in_reset", 128'(s_irv), 128'(0));
    end
    i_raddr = 32'h3000_0058; i_ren = 1'b1;
    add_txn(1'b0, 32'h3000_0050, 0, 1'b0, 4, 1'b1, 16'hFFFF,
            {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001},
            128'h66660004_66660003_66660002_66660001, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    step();
    chk(s_arv && s_arid == 4'd0 && s_araddr == 32'h3000_0050, "t7_first_after_release",
        128'({s_arv, s_arid, s_araddr}), 128'({1'b1, 4'd0, 32'h3000_0050}));
    wait_idle("t7_post_reset_done");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog_timeout actual=expired required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/mem_read_arbiter.md
MEM_READ_ARBITER -- requirements
Module: mem_read_arbiter

Interface
REQ-001 Parameter: DCACHE_FIRST, default 1, fixed priority selector (1 = dcache wins simultaneous requests, 0 = icache wins).
REQ-002 Port: clk  in  1  sole clock, all logic on rising edge.
REQ-003 Port: rst  in  1  reset, asynchronous, active-low.
REQ-004 Port: i_ren  in  1  icache line-read request, level, held until i_ren_received.
REQ-005 Port: i_raddr  in  32  icache line address.
REQ-006 Port: i_rrdy  out  1  arbiter idle and able to accept icache.
REQ-007 Port: i_ren_received  out  1  one-cycle pulse, icache address accepted by bus.
REQ-008 Port: i_rvalid  out  1  one-cycle pulse, i_rdata holds the completed line.
REQ-009 Port: i_rdata  out  128  assembled icache line, beat0 in [31:0].
REQ-010 Port: i_flush_flag_valid  out  1  icache read outstanding (accepted, line not yet returned).
REQ-011 Ports: d_ren, d_raddr, d_rrdy, d_ren_received, d_rvalid, d_rdata, same directions, widths and meaning as REQ-004..009 for dcache.
REQ-012 Ports: ar_valid out 1, ar_ready in 1, ar_addr out 32, ar_id out 4, ar_len out 8, ar_size out 3, ar_burst out 2: bus read-address channel.
REQ-013 Ports: r_valid in 1, r_ready out 1, r_data in 32, r_last in 1: bus read-data channel.

Function
REQ-014 States: IDLE, AR_I, AR_D, R_I, R_D; one transaction outstanding at a time.
REQ-015 IDLE: i_rrdy = d_rrdy = 1; all other states 0.
REQ-016 IDLE with one request: go to AR_I/AR_D next cycle; both requesting: winner per DCACHE_FIRST, loser stays pending.
REQ-017 On leaving IDLE, latch line address {raddr[31:4],4'b0}; ar_addr driven from latch, stable through AR state.
REQ-018 AR_x: ar_valid = 1; ar_id = 0 (icache) / 1 (dcache); ar_len = 8'd3; ar_size = 3'b010; ar_burst = 2'b01; outside AR_x ar_valid = 0.
REQ-019 ar_valid & ar_ready in AR_x: x_ren_received = 1 that same cycle (combinational), next state R_x, beat counter cleared.
REQ-020 ar_valid never deasserts before handshake; ar_ready stall of any length tolerated.
REQ-021 R_x: r_ready = 1; every r_valid & r_ready writes r_data into line buffer slot [cnt*32 +: 32], cnt (2 bits) increments, wraps modulo 4.
REQ-022 Completion on r_valid & r_ready & r_last regardless of cnt: next cycle x_rvalid = 1 for exactly one cycle, x_rdata = buffer including final beat, state IDLE.
REQ-023 x_rdata holds last completed line until next completion for same requester; never changes for the other requester's traffic.
REQ-024 i_flush_flag_valid = 1 from cycle after icache AR handshake through cycle i_rvalid pulses; i_rvalid always pulses for accepted icache reads (icache flush bookkeeping depends on it).
REQ-025 Request sampled in the same cycle x_rvalid pulses (state IDLE): accepted normally, back-to-back, no bubble beyond REQ-016.
REQ-026 Request dropped while in IDLE before selection: no transaction issued; dropped after ren_received: ignored, transaction completes.
REQ-027 r_valid in IDLE/AR_x: ignored (r_ready = 0), no buffer write.

Reset
REQ-028 rst low: state IDLE, cnt 0, buffer and x_rdata 0, ar_valid 0, r_ready 0, all ren_received/rvalid/flush_flag_valid 0, ar_addr 0, immediately and asynchronously.
REQ-029 rst asserted mid-transaction: transaction abandoned, no rvalid after release; release synchronous to clk, first request accepted in first post-release cycle in IDLE.

Verification
REQ-030 Single icache read 0x1C00_0024, ar_ready=1, beats 0x11,0x22,0x33,0x44 -> ar_addr 0x1C00_0020, ar_id 0, i_ren_received pulse, i_rvalid one cycle later than r_last, i_rdata 0x00000044_00000033_00000022_00000011.
REQ-031 i_ren and d_ren same cycle, DCACHE_FIRST=1 -> dcache AR first (ar_id 1), icache AR issued cycle after d_rvalid; with DCACHE_FIRST=0 order reversed.
REQ-032 ar_ready held 0 for 5 cycles -> ar_valid and ar_addr stable 5 cycles, ren_received only on handshake cycle.
REQ-033 r_valid gaps between beats (1,0,0,1,1,0,1) -> exactly 4 writes, correct slot order, single rvalid pulse; d_rdata unchanged during icache reads.
REQ-034 rst driven low after 2 beats of an icache read -> all outputs 0 same cycle, no i_rvalid after release, next request completes correctly.
